regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 4-entry x 8-bit register file between NUM_REQ writeback sources (0 = ALU, 1 = load data, 2 = debug/host).
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered write-port outputs, one cycle after grant.
- Pending-write mask lets the control unit detect read-after-write hazards on the register file.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..4)
DW, 8, register data width
AW, 2, register address width (register count = 2**AW)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
hold  input  1  control-unit stall; no new grants while high
req_valid  input  NUM_REQ  per-requester write request
req_reg  input  NUM_REQ*AW  per-requester target register, requester i at bits [i*AW +: AW]
req_data  input  NUM_REQ*DW  per-requester write data, requester i at bits [i*DW +: DW]
req_ready  output  NUM_REQ  one-hot grant, combinational, same cycle as valid
write_en  output  1  to register file write enable (registered)
write_reg  output  AW  to register file write address (registered)
write_data  output  DW  to register file write data (registered)
grant_id  output  $clog2(NUM_REQ)  index of requester whose write is on write_en (registered)
pending_mask  output  2**AW  bit r set while a granted write to register r has not yet committed

Behaviour:
- Reset, asynchronous: write_en=0, write_reg=0, write_data=0, grant_id=0, rr_ptr=0. While reset is high, req_ready=0 and pending_mask=0.
- Handshake:
  - A transfer occurs in a cycle where req_valid[i] and req_ready[i] are both 1.
  - Requester holds valid, reg and data stable until its transfer completes.
  - req_ready[i] is never 1 unless req_valid[i] is 1.
  - At most one ready bit is set per cycle.
- Arbitration, round-robin:
  - The search starts at rr_ptr and wraps modulo NUM_REQ. The first valid requester found is granted.
  - On a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no grant, rr_ptr is unchanged.
- hold=1: req_ready=0 for all requesters and rr_ptr is frozen.
- Latency:
  - Grant in cycle T. At the end of T: write_en<=1, write_reg<=req_reg[i], write_data<=req_data[i], grant_id<=i.
  - The register file commits at the end of T+1.
  - With no grant in T, write_en<=0 and write_reg/write_data/grant_id hold their values.
- Back-to-back grants are allowed: full throughput of one write per cycle.
- pending_mask is combinational:
  - Bit r = (write_en && write_reg==r) OR (any req_ready[i] && req_reg[i]==r).
  - This covers the grant cycle and the commit cycle.
- Two requesters targeting the same register in the same cycle: only the RR winner is granted. The loser stays valid and is granted in a later cycle, so writes land in grant order.
- A requester that deasserts valid before ready violates protocol. It is not checked, but must not lock up the arbiter.
- Reset asserted mid-transfer: the registered write is dropped (write_en forced 0 asynchronously). Requesters re-request after reset.

Optional Feature:
REGARB_DEBUG_PRIO_EN
- Defined: requester NUM_REQ-1 (debug) has absolute priority over round-robin. When it is valid and hold=0 it is granted and rr_ptr is unchanged. The other requesters use round-robin as usual.
- Undefined: pure round-robin across all requesters.

Decomposition:
- Shared package regarb_pkg:
  - constants REG_COUNT=4, DW=8, AW=2.
  - typedef reg_addr_t (logic [AW-1:0]), reg_data_t (logic [DW-1:0]).
  - localparam requester indices REQ_ALU=0, REQ_LOAD=1, REQ_DBG=2.
- One sub-module: rr_arbiter (NUM_REQ). It takes a request vector, rr_ptr and an enable, and returns a one-hot grant plus the granted index. It is combinational; the pointer register lives in the top.
- Write-port registers and pending_mask stay in regfile_write_arbiter.

Test Plan:
- Reset, then a single request: req_valid=001, reg=2, data=8'hA5 → ready=001 in T; write_en=1, write_reg=2, write_data=A5, grant_id=0 in T+1; pending_mask=0100 in T and T+1, 0000 in T+2.
- All three valid and held for 6 cycles, rr_ptr=0 → grant order 0,1,2,0,1,2; write_en high every cycle from T+1.
- Same-register collision: req0 reg=1 data=11, req1 reg=1 data=22, both valid → 11 is written first, then 22. The final register file R1 = 8'h22.
- hold=1 for 3 cycles with req1 valid → ready stays 0. write_en drops the cycle after hold rises. The grant to req1 happens on the first cycle hold=0.
- Reset pulse in the cycle after a grant → write_en=0 immediately, pending_mask=0, rr_ptr=0. The next grant with all valid goes to requester 0.
- REGARB_DEBUG_PRIO_EN defined, all valid for 4 cycles → debug is granted all 4 cycles. After debug drops, round-robin resumes at the pre-debug rr_ptr.

Source files
------------

// File: rtl/regarb_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Requester index constants name the fixed writeback sources.
package regarb_pkg;

    localparam int REG_COUNT = 4;
    localparam int DW        = 8;
    localparam int AW        = 2;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_DBG  = 2;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshake plus register-file write port of the write arbiter.
// Valid/ready: a write transfers in a cycle where req_valid[i] && req_ready[i]; the requester holds valid/reg/data stable until then.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DW      = regarb_pkg::DW,
    parameter int AW      = regarb_pkg::AW
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*AW-1:0] req_reg;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  write_en;
    logic [AW-1:0]         write_reg;
    logic [DW-1:0]         write_data;
    logic [IW-1:0]         grant_id;
    logic [(1<<AW)-1:0]    pending_mask;

    // Requesters and register file side.
    modport master (
        output req_valid, req_reg, req_data,
        input  req_ready, write_en, write_reg, write_data, grant_id, pending_mask
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_reg, req_data,
        output req_ready, write_en, write_reg, write_data, grant_id, pending_mask
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after ptr, wrapping modulo NUM_REQ.
// The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);

    int         slot;
    logic [IW-1:0] cand;
    logic       found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        slot  = 0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = int'(ptr) + k;
            if (slot >= NUM_REQ) slot = slot - NUM_REQ;
            cand = IW'(slot);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources with round-robin grants.
// Optional REGARB_DEBUG_PRIO_EN gives requester NUM_REQ-1 absolute priority without moving rr_ptr.
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DW      = regarb_pkg::DW,
    parameter int AW      = regarb_pkg::AW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hold,
    regfile_write_arbiter_if.slave  bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RC = 1 << AW;

    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      arb_idx;
    logic [IW-1:0]      grant_idx;
    logic [NUM_REQ-1:0] arb_grant;
    logic [NUM_REQ-1:0] grant;
    logic               arb_en;
    logic               dbg_grant;
    logic               grant_any;
    logic [AW-1:0]      sel_reg;
    logic [DW-1:0]      sel_data;
    logic [RC-1:0]      pending;

    // Reset gating keeps ready low while reset is held, even between clock edges.
    assign arb_en = !reset && !hold;

`ifdef REGARB_DEBUG_PRIO_EN
    assign dbg_grant = arb_en && bus.req_valid[NUM_REQ-1];
`else
    assign dbg_grant = 1'b0;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .en    (arb_en && !dbg_grant),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        grant     = arb_grant;
        grant_idx = arb_idx;
        if (dbg_grant) begin
            grant              = '0;
            grant[NUM_REQ-1]   = 1'b1;
            grant_idx          = IW'(NUM_REQ - 1);
        end
    end

    assign grant_any     = |grant;
    assign bus.req_ready = grant;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_reg  = bus.req_reg[i*AW +: AW];
                sel_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_any && !dbg_grant) begin
            rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.write_en   <= 1'b0;
            bus.write_reg  <= '0;
            bus.write_data <= '0;
            bus.grant_id   <= '0;
        end else begin
            bus.write_en <= grant_any;
            if (grant_any) begin
                bus.write_reg  <= sel_reg;
                bus.write_data <= sel_data;
                bus.grant_id   <= grant_idx;
            end
        end
    end

    // Covers both the grant cycle and the following commit cycle.
    always_comb begin
        pending = '0;
        if (bus.write_en) pending[bus.write_reg] = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) pending[bus.req_reg[i*AW +: AW]] = 1'b1;
        end
    end

    assign bus.pending_mask = pending;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed steps then random traffic against a grant-order scoreboard.
// Build with REGARB_DEBUG_PRIO_EN defined to exercise debug priority.
module tb_regfile_write_arbiter;
    import regarb_pkg::*;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int RC = REG_COUNT;
    localparam int EW = IW + AW + DW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic hold  = 1'b0;

    logic [N-1:0]  rv;
    logic [AW-1:0] rr [N];
    logic [DW-1:0] rd [N];

    regfile_write_arbiter_if #(.NUM_REQ(N), .DW(DW), .AW(AW)) bus ();

    regfile_write_arbiter #(.NUM_REQ(N), .DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .hold  (hold),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.req_valid = rv;
        bus.req_reg   = '0;
        bus.req_data  = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_reg[i*AW +: AW]  = rr[i];
            bus.req_data[i*DW +: DW] = rd[i];
        end
    end

    // Scoreboard: writes expected on the port, in grant order, as {id, reg, data}.
    logic [EW-1:0] exp_q[$];
    int            exp_ptr;
    logic [IW-1:0] last_gid;
    logic [AW-1:0] last_reg;
    logic [DW-1:0] last_data;
    logic [DW-1:0] rf [RC];
    int            tests;
    int            fails;
    int            last_g;
    logic [N-1:0]  obs_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_ptr   = 0;
        last_gid  = '0;
        last_reg  = '0;
        last_data = '0;
    endtask

    // Called at posedge+1 with inputs applied; checks mid-cycle, returns at next posedge+1.
    task automatic tick();
        int            g;
        logic [N-1:0]  er;
        logic [RC-1:0] epm;
        logic [EW-1:0] e;
        logic          had;
        #2;
        if (reset) model_clear();
        g = -1;
        if (!reset && !hold) begin
`ifdef REGARB_DEBUG_PRIO_EN
            if (rv[N-1]) g = N - 1;
`endif
            for (int k = 0; k < N; k++)
                if (g < 0 && rv[(exp_ptr + k) % N]) g = (exp_ptr + k) % N;
        end
        er  = '0;
        epm = '0;
        if (g >= 0) begin
            er[g]      = 1'b1;
            epm[rr[g]] = 1'b1;
        end
        had = (exp_q.size() > 0);
        if (had) begin
            e         = exp_q.pop_front();
            last_gid  = e[DW+AW +: IW];
            last_reg  = e[DW +: AW];
            last_data = e[DW-1:0];
            epm[last_reg] = 1'b1;
        end
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("pending_mask", 32'(bus.pending_mask), 32'(epm));
        chk("write_en", 32'(bus.write_en), 32'(had));
        chk("write_reg", 32'(bus.write_reg), 32'(last_reg));
        chk("write_data", 32'(bus.write_data), 32'(last_data));
        chk("grant_id", 32'(bus.grant_id), 32'(last_gid));
        if (bus.write_en === 1'b1) rf[bus.write_reg] = bus.write_data;
        obs_rdy = bus.req_ready;
        last_g  = g;
        if (g >= 0) begin
            exp_q.push_back({IW'(g), rr[g], rd[g]});
`ifdef REGARB_DEBUG_PRIO_EN
            if (g != N - 1) exp_ptr = (g + 1) % N;
`else
            exp_ptr = (g + 1) % N;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        rv    = '0;
        for (int i = 0; i < N; i++) begin
            rr[i] = '0;
            rd[i] = '0;
        end
        for (int r = 0; r < RC; r++) rf[r] = '0;
        model_clear();
        last_g  = -1;
        obs_rdy = '0;

        // Reset state, then release.
        @(posedge clk);
        #1;
        rv = 3'b111;
        tick();
        reset = 1'b0;
        rv    = '0;
        tick();

        // Single request from ALU: reg 2, data A5.
        rv = 3'b001; rr[0] = 2'd2; rd[0] = 8'hA5;
        tick();
        chk("single_ready", 32'(obs_rdy), 32'h1);
        rv = '0;
        tick();
        tick();

        // All requesters valid for 6 cycles from rr_ptr=0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            rr[i] = AW'(i);
            rd[i] = DW'(8'h10 * (i + 1));
        end
        rv = 3'b111;
        for (int c = 0; c < 6; c++) begin
            tick();
`ifndef REGARB_DEBUG_PRIO_EN
            chk("rr_order", 32'(obs_rdy), 32'(1 << (c % 3)));
`endif
        end
        rv = '0;
        tick();
        tick();

        // Two requesters targeting R1 in the same cycle.
        rv = 3'b011;
        rr[0] = 2'd1; rd[0] = 8'h11;
        rr[1] = 2'd1; rd[1] = 8'h22;
        repeat (2) begin
            tick();
            if (last_g >= 0) rv[last_g] = 1'b0;
        end
        rv = '0;
        tick();
        tick();
        chk("collision_rf1", 32'(rf[1]), 32'h22);

        // hold for 3 cycles right after a grant.
        rv = 3'b001; rr[0] = 2'd0; rd[0] = 8'h33;
        tick();
        rv = 3'b010; rr[1] = 2'd3; rd[1] = 8'h5C;
        hold = 1'b1;
        repeat (3) begin
            tick();
            chk("hold_ready", 32'(obs_rdy), 32'h0);
        end
        hold = 1'b0;
        tick();
        chk("hold_release", 32'(obs_rdy), 32'h2);
        rv = '0;
        tick();
        tick();

        // Reset pulse in the cycle after a grant.
        rv = 3'b111;
        for (int i = 0; i < N; i++) begin
            rr[i] = AW'(3 - i);
            rd[i] = DW'(8'hC0 + i);
        end
        tick();
        chk("pre_reset_we", 32'(bus.write_en), 32'h1);
        reset = 1'b1;
        #1;
        chk("async_reset_we", 32'(bus.write_en), 32'h0);
        chk("async_reset_pm", 32'(bus.pending_mask), 32'h0);
        chk("async_reset_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        tick();
`ifndef REGARB_DEBUG_PRIO_EN
        chk("post_reset_grant", 32'(obs_rdy), 32'h1);
`endif
        rv = '0;
        tick();
        tick();

`ifdef REGARB_DEBUG_PRIO_EN
        // Debug priority: pointer parked at 1 before debug traffic.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rv = 3'b001;
        tick();
        rv = 3'b111;
        repeat (4) begin
            tick();
            chk("dbg_prio", 32'(obs_rdy), 32'h4);
        end
        rv = 3'b011;
        tick();
        chk("dbg_resume", 32'(obs_rdy), 32'h2);
        rv = '0;
        tick();
        tick();
`endif

        // Random traffic with occasional hold.
        repeat (300) begin
            for (int i = 0; i < N; i++) begin
                if (!rv[i] && $urandom_range(0, 2) == 0) begin
                    rv[i] = 1'b1;
                    rr[i] = AW'($urandom_range(0, RC - 1));
                    rd[i] = DW'($urandom_range(0, 255));
                end
            end
            hold = ($urandom_range(0, 4) == 0);
            tick();
            if (last_g >= 0) rv[last_g] = 1'b0;
        end
        hold = 1'b0;
        rv   = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
